precursor_tracker_multi: RTL and testbench
==========================================

Name: precursor_tracker_multi

Overview:
- Parametrised successor to the single-group delayed-neutron precursor tracker.
- Tracks NUM_GROUPS delayed-neutron precursor groups. Each group has its own beta (yield fraction) and lambda (decay constant), loaded at runtime.
- Groups are updated time-multiplexed, one per cycle, on each new_timestep. The summed delayed-neutron source is presented to the reactor kinetics loop.
- Sits between the flux integrator (neutron_flux source) and the neutron population update (precursor_neutrons sink).

Parameters:
- NUM_GROUPS, 6, number of precursor groups (1..16).
- FLUX_WIDTH, 51, width of neutron_flux.
- ACC_WIDTH, 64, width of per-group concentration registers and of precursor_neutrons.
- COEF_WIDTH, 32, width of beta/lambda coefficients, unsigned Q8.24.
- COEF_FRAC, 24, fractional bits of coefficients.
- LOG2_STEPS_PER_SECOND, 14, timestep = 2^-LOG2_STEPS_PER_SECOND s.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- new_timestep  in  1  single-cycle pulse starting one update
- neutron_flux  in  FLUX_WIDTH  current flux; sampled on the accepted new_timestep
- coef_we  in  1  coefficient write strobe
- coef_sel  in  1  0 = beta, 1 = lambda
- coef_addr  in  4  group index
- coef_data  in  COEF_WIDTH  coefficient value
- busy  out  1  update in progress
- done  out  1  one-cycle pulse when precursor_neutrons is updated
- overrun  out  1  one-cycle pulse when new_timestep arrives while busy
- coef_err  out  1  one-cycle pulse when a coefficient write is rejected
- precursor_neutrons  out  ACC_WIDTH  sum over groups of lambda_k*C_k

Behaviour:
- Reset: C_k = 0 for all k; beta/lambda registers = package default tables; precursor_neutrons = 0; busy = done = overrun = coef_err = 0; FSM = IDLE.
- FSM states:
  - IDLE: on new_timestep, latch neutron_flux, clear the sum accumulator, set g = 0, go to SCAN; busy rises next cycle.
  - SCAN: one group per cycle, g = 0..NUM_GROUPS-1. After g = NUM_GROUPS-1, go to FINISH.
  - FINISH: precursor_neutrons <= accumulated sum; done = 1 for that cycle; return to IDLE.
- Latency: done is asserted NUM_GROUPS+1 cycles after the accepted new_timestep cycle.
- new_timestep is accepted again from the cycle after FINISH.
- Per-group math, using the pre-update C_k throughout:
  - prod = flux * beta_k, full precision.
  - src_k = (C_k * lambda_k) >> COEF_FRAC.
  - dec_k = src_k >> LOG2_STEPS_PER_SECOND.
  - C_k <= C_k + (prod >> COEF_FRAC) - dec_k. If the result is negative, C_k <= 0 (always floored).
  - sum += src_k. The accumulator is ACC_WIDTH + 4 bits wide.
- Output width: truncate to ACC_WIDTH when writing precursor_neutrons (see Optional Feature). Intermediate products are never truncated before the shift.
- new_timestep while busy (SCAN or FINISH): ignored; overrun pulses for 1 cycle. The in-flight update completes with the original latched flux.
- coef_we:
  - In IDLE: write takes effect next cycle.
  - While busy: rejected, coef_err pulses.
  - coef_addr >= NUM_GROUPS: rejected, coef_err pulses.
- coef_we and new_timestep in the same IDLE cycle: the write is applied and the update starts. The scan uses the new coefficient.
- Reset mid-SCAN: abort immediately; all state returns to reset values; no done pulse.
- flux = 0 with lambda > 0: C_k decays monotonically and never goes below 0.

Optional Feature:
- Macro PRECURSOR_TRACKER_SATURATE_EN.
- Defined: if the accumulated sum exceeds 2^ACC_WIDTH-1, precursor_neutrons = all ones. C_k updates whose sum exceeds 2^ACC_WIDTH-1 clamp to all ones.
- Undefined: both values wrap modulo 2^ACC_WIDTH.

Decomposition:
- precursor_pkg:
  - FSM state enum {IDLE, SCAN, FINISH}.
  - Default 6-group U-235 tables in Q8.24: DEFAULT_BETA[0:15] and DEFAULT_LAMBDA[0:15] (unused entries 0).
  - Widths for the coefficient select encoding.
- Sub-module precursor_group_alu, combinational:
  - Inputs: flux, C_k, beta_k, lambda_k.
  - Outputs: C_next, src_k, including the floor and the optional saturation.
- The top level holds the FSM, the register files and the accumulator.

Test Plan:
1. Reset, then read state: precursor_neutrons = 0, busy = 0; a single new_timestep with flux = 0 gives done at cycle NUM_GROUPS+1 with output 0.
2. NUM_GROUPS = 2; group 0 set to beta = 2^24 (1.0), lambda = 0; group 1 set to all zero; flux = 1000, one step:
   - C0 = 1000, output 0.
   - Then set lambda0 = 2^24 and run a second step with flux = 1000: output = 1000, C0 = 2000.
3. beta = 0, lambda0 = 2^24, C0 preloaded to 2^20 by repeated steps; run with flux = 0: C0 decreases by 64 per step; output equals the pre-step C0.
4. Pulse new_timestep on the 2nd cycle of SCAN: overrun = 1 for one cycle; exactly one done pulse; result matches the original flux.
5. coef_we while busy, and coef_we with coef_addr = NUM_GROUPS in IDLE: coef_err pulses both times; a subsequent step matches the unchanged coefficients.
6. With PRECURSOR_TRACKER_SATURATE_EN: force the sum past 2^64-1 (lambda = 0xFFFFFFFF, C near 2^63), output = 0xFFFF_FFFF_FFFF_FFFF. Without the macro: the output equals the sum mod 2^64.

Source files
------------

// File: rtl/precursor_pkg.sv
// Shared types and constants for the multi-group delayed-neutron precursor tracker.
package precursor_pkg;

    localparam int unsigned MAX_GROUPS  = 16;
    localparam int unsigned COEF_ADDR_W = 4;
    localparam int unsigned COEF_SEL_W  = 1;
    localparam int unsigned DEF_COEF_W  = 32;

    localparam logic [COEF_SEL_W-1:0] COEF_SEL_LAMBDA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_e;

    // U-235 six-group data in Q8.24; unused groups are zero.
    localparam logic [DEF_COEF_W-1:0] DEFAULT_BETA [0:MAX_GROUPS-1] = '{
        32'd3607, 32'd23891, 32'd21374, 32'd43084, 32'd12549, 32'd4580,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0
    };

    localparam logic [DEF_COEF_W-1:0] DEFAULT_LAMBDA [0:MAX_GROUPS-1] = '{
        32'd208038, 32'd511705, 32'd1862271, 32'd5049942, 32'd19126026, 32'd50499420,
        32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0
    };

endpackage

// File: rtl/precursor_group_alu.sv
// One precursor group step: new concentration (floored at zero) and its decay source.
// PRECURSOR_TRACKER_SATURATE_EN clamps the concentration instead of wrapping.
module precursor_group_alu #(
    parameter int unsigned FLUX_WIDTH            = 51,
    parameter int unsigned ACC_WIDTH             = 64,
    parameter int unsigned COEF_WIDTH            = 32,
    parameter int unsigned COEF_FRAC             = 24,
    parameter int unsigned LOG2_STEPS_PER_SECOND = 14
) (
    input  logic [FLUX_WIDTH-1:0]                     flux_i,
    input  logic [ACC_WIDTH-1:0]                      conc_i,
    input  logic [COEF_WIDTH-1:0]                     beta_i,
    input  logic [COEF_WIDTH-1:0]                     lambda_i,
    output logic [ACC_WIDTH-1:0]                      conc_next_o,
    output logic [ACC_WIDTH+COEF_WIDTH-COEF_FRAC-1:0] src_o
);

    localparam int unsigned PROD_W = FLUX_WIDTH + COEF_WIDTH;
    localparam int unsigned CL_W   = ACC_WIDTH + COEF_WIDTH;
    localparam int unsigned SRC_W  = CL_W - COEF_FRAC;
    localparam int unsigned WIDE_W = PROD_W + CL_W;

    logic [PROD_W-1:0] prod;
    logic [CL_W-1:0]   conc_lambda;
    logic [WIDE_W-1:0] grow;
    logic [WIDE_W-1:0] dec;
    logic [WIDE_W-1:0] diff;

    // Products kept at full precision; only the final result is narrowed.
    always_comb begin
        prod        = PROD_W'(flux_i) * PROD_W'(beta_i);
        conc_lambda = CL_W'(conc_i) * CL_W'(lambda_i);
        src_o       = SRC_W'(conc_lambda >> COEF_FRAC);
        dec         = WIDE_W'(src_o >> LOG2_STEPS_PER_SECOND);
        grow        = WIDE_W'(conc_i) + WIDE_W'(prod >> COEF_FRAC);
        diff        = (grow > dec) ? (grow - dec) : '0;
        conc_next_o = ACC_WIDTH'(diff);
`ifdef PRECURSOR_TRACKER_SATURATE_EN
        if (|(diff >> ACC_WIDTH)) begin
            conc_next_o = '1;
        end
`endif
    end

endmodule

// File: rtl/precursor_tracker_multi.sv
// Time-multiplexed NUM_GROUPS precursor tracker producing the summed delayed-neutron source.
// PRECURSOR_TRACKER_SATURATE_EN saturates the output sum instead of wrapping.
module precursor_tracker_multi
    import precursor_pkg::*;
#(
    parameter int unsigned NUM_GROUPS            = 6,
    parameter int unsigned FLUX_WIDTH            = 51,
    parameter int unsigned ACC_WIDTH             = 64,
    parameter int unsigned COEF_WIDTH            = 32,
    parameter int unsigned COEF_FRAC             = 24,
    parameter int unsigned LOG2_STEPS_PER_SECOND = 14
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   new_timestep,
    input  logic [FLUX_WIDTH-1:0]  neutron_flux,
    input  logic                   coef_we,
    input  logic [COEF_SEL_W-1:0]  coef_sel,
    input  logic [COEF_ADDR_W-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]  coef_data,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic                   coef_err,
    output logic [ACC_WIDTH-1:0]   precursor_neutrons
);

    localparam int unsigned SRC_W      = ACC_WIDTH + COEF_WIDTH - COEF_FRAC;
    localparam int unsigned ACCUM_W    = ACC_WIDTH + 4;
    localparam int unsigned ADD_W      = ((SRC_W > ACCUM_W) ? SRC_W : ACCUM_W) + 1;
    localparam int unsigned ADDR_CMP_W = COEF_ADDR_W + 1;
    localparam logic [COEF_ADDR_W-1:0] G_LAST    = COEF_ADDR_W'(NUM_GROUPS - 1);
    localparam logic [ADDR_CMP_W-1:0]  NUM_G_CMP = ADDR_CMP_W'(NUM_GROUPS);

    state_e                 state_q, state_d;
    logic [COEF_ADDR_W-1:0] g_q, g_d;
    logic [FLUX_WIDTH-1:0]  flux_q, flux_d;
    logic [ACCUM_W-1:0]     acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   coef_err_q, coef_err_d;

    logic [ACC_WIDTH-1:0]  conc_q   [MAX_GROUPS];
    logic [COEF_WIDTH-1:0] beta_q   [MAX_GROUPS];
    logic [COEF_WIDTH-1:0] lambda_q [MAX_GROUPS];

    logic [ACC_WIDTH-1:0] conc_next;
    logic [SRC_W-1:0]     src;
    logic [ADD_W-1:0]     add_w;
    logic                 coef_ok;

    assign coef_ok = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < NUM_G_CMP);

    precursor_group_alu #(
        .FLUX_WIDTH            (FLUX_WIDTH),
        .ACC_WIDTH             (ACC_WIDTH),
        .COEF_WIDTH            (COEF_WIDTH),
        .COEF_FRAC             (COEF_FRAC),
        .LOG2_STEPS_PER_SECOND (LOG2_STEPS_PER_SECOND)
    ) u_alu (
        .flux_i      (flux_q),
        .conc_i      (conc_q[g_q]),
        .beta_i      (beta_q[g_q]),
        .lambda_i    (lambda_q[g_q]),
        .conc_next_o (conc_next),
        .src_o       (src)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        flux_d     = flux_q;
        acc_d      = acc_q;
        out_d      = out_q;
        done_d     = 1'b0;
        add_w      = ADD_W'(acc_q) + ADD_W'(src);
        overrun_d  = new_timestep && (state_q != IDLE);
        coef_err_d = coef_we && !coef_ok;
        unique case (state_q)
            IDLE: begin
                if (new_timestep) begin
                    flux_d  = neutron_flux;
                    acc_d   = '0;
                    g_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d = ACCUM_W'(add_w);
`ifdef PRECURSOR_TRACKER_SATURATE_EN
                if (|(add_w >> ACCUM_W)) begin
                    acc_d = '1;
                end
`endif
                if (g_q == G_LAST) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    out_d   = ACC_WIDTH'(acc_d);
`ifdef PRECURSOR_TRACKER_SATURATE_EN
                    if (|(acc_d >> ACC_WIDTH)) begin
                        out_d = '1;
                    end
`endif
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            g_q        <= '0;
            flux_q     <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            flux_q     <= flux_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            coef_err_q <= coef_err_d;
        end
    end

    // Coefficient and concentration register files.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < MAX_GROUPS; k++) begin
                conc_q[COEF_ADDR_W'(k)]   <= '0;
                beta_q[COEF_ADDR_W'(k)]   <= COEF_WIDTH'(DEFAULT_BETA[COEF_ADDR_W'(k)]);
                lambda_q[COEF_ADDR_W'(k)] <= COEF_WIDTH'(DEFAULT_LAMBDA[COEF_ADDR_W'(k)]);
            end
        end else begin
            if (coef_ok) begin
                if (coef_sel == COEF_SEL_LAMBDA) begin
                    lambda_q[coef_addr] <= coef_data;
                end else begin
                    beta_q[coef_addr] <= coef_data;
                end
            end
            if (state_q == SCAN) begin
                conc_q[g_q] <= conc_next;
            end
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign overrun            = overrun_q;
    assign coef_err           = coef_err_q;
    assign precursor_neutrons = out_q;

endmodule

// File: tb/tb_precursor_tracker_multi.sv
// Directed bench for precursor_tracker_multi with two groups; vector table plus corner sequences.
module tb_precursor_tracker_multi;

    localparam int NG = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        new_timestep;
    logic [50:0] neutron_flux;
    logic        coef_we;
    logic [0:0]  coef_sel;
    logic [3:0]  coef_addr;
    logic [31:0] coef_data;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        coef_err;
    logic [63:0] precursor_neutrons;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    precursor_tracker_multi #(.NUM_GROUPS(NG)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .new_timestep       (new_timestep),
        .neutron_flux       (neutron_flux),
        .coef_we            (coef_we),
        .coef_sel           (coef_sel),
        .coef_addr          (coef_addr),
        .coef_data          (coef_data),
        .busy               (busy),
        .done               (done),
        .overrun            (overrun),
        .coef_err           (coef_err),
        .precursor_neutrons (precursor_neutrons)
    );

    typedef struct {
        bit          rst;
        logic [31:0] beta0;
        logic [31:0] lambda0;
        logic [50:0] flux;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] data);
        coef_we   = 1'b1;
        coef_sel  = sel;
        coef_addr = addr;
        coef_data = data;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        wr(1'b0, 4'd1, 32'd0);
        wr(1'b1, 4'd1, 32'd0);
    endtask

    // Start one update, wait for done, check latency and result, return to IDLE.
    task automatic step(input logic [50:0] flux, input logic [63:0] exp, input string name);
        int n;
        new_timestep = 1'b1;
        neutron_flux = flux;
        tick();
        new_timestep = 1'b0;
        coef_we      = 1'b0;
        chk({name, " busy"}, 64'(busy), 64'd1);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(NG + 1));
        chk(name, precursor_neutrons, exp);
        tick();
        chk({name, " idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int dp;
        rst_in       = 1'b1;
        new_timestep = 1'b0;
        neutron_flux = '0;
        coef_we      = 1'b0;
        coef_sel     = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;

        vecs[0] = '{1'b1, 32'h0100_0000, 32'h0,         51'd1000,    64'd0};
        vecs[1] = '{1'b0, 32'h0100_0000, 32'h0100_0000, 51'd1000,    64'd1000};
        vecs[2] = '{1'b0, 32'h0,         32'h0100_0000, 51'd0,       64'd2000};
        vecs[3] = '{1'b1, 32'h0100_0000, 32'h0,         51'd1048576, 64'd0};
        vecs[4] = '{1'b0, 32'h0,         32'h0100_0000, 51'd0,       64'd1048576};
        vecs[5] = '{1'b0, 32'h0,         32'h0100_0000, 51'd0,       64'd1048512};
        vecs[6] = '{1'b0, 32'h0,         32'h0100_0000, 51'd0,       64'd1048449};
        vecs[7] = '{1'b0, 32'h0100_0000, 32'h0100_0000, 51'd0,       64'd1048386};
        vecs[8] = '{1'b0, 32'h0080_0000, 32'h0,         51'd3,       64'd0};
        vecs[9] = '{1'b0, 32'h0,         32'h0080_0000, 51'd0,       64'd524162};

        tick();
        tick();
        rst_in = 1'b0;
        chk("reset out", precursor_neutrons, 64'd0);
        chk("reset flags", 64'({busy, done, overrun, coef_err}), 64'd0);

        step(51'd0, 64'd0, "default flux0");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            wr(1'b0, 4'd0, vecs[i].beta0);
            wr(1'b1, 4'd0, vecs[i].lambda0);
            step(vecs[i].flux, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Second new_timestep during SCAN must be ignored and flagged.
        wr(1'b0, 4'd0, 32'h0100_0000);
        wr(1'b1, 4'd0, 32'h0100_0000);
        new_timestep = 1'b1;
        neutron_flux = 51'd500;
        tick();
        new_timestep = 1'b0;
        chk("ovr quiet", 64'(overrun), 64'd0);
        tick();
        new_timestep = 1'b1;
        neutron_flux = 51'd7777;
        tick();
        new_timestep = 1'b0;
        neutron_flux = 51'd0;
        chk("ovr pulse", 64'(overrun), 64'd1);
        chk("ovr done", 64'(done), 64'd1);
        chk("ovr out", precursor_neutrons, 64'd1048293);
        tick();
        chk("ovr clear", 64'({overrun, done}), 64'd0);
        dp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dp++;
        end
        chk("ovr single done", 64'(dp), 64'd0);
        step(51'd0, 64'd1048730, "ovr orig flux");

        // Coefficient write while busy is rejected.
        new_timestep = 1'b1;
        neutron_flux = 51'd0;
        tick();
        new_timestep = 1'b0;
        coef_we   = 1'b1;
        coef_sel  = 1'b1;
        coef_addr = 4'd0;
        coef_data = 32'd0;
        tick();
        coef_we = 1'b0;
        chk("busy wr err", 64'(coef_err), 64'd1);
        tick();
        chk("busy wr done", 64'(done), 64'd1);
        chk("busy wr out", precursor_neutrons, 64'd1048666);
        chk("busy wr err clr", 64'(coef_err), 64'd0);
        tick();

        // Out-of-range group index is rejected in IDLE.
        wr(1'b1, 4'(NG), 32'd0);
        chk("addr err", 64'(coef_err), 64'd1);
        tick();
        chk("addr err clr", 64'(coef_err), 64'd0);
        step(51'd0, 64'd1048602, "coef unchanged");

        // Write and start in the same IDLE cycle: scan sees the new lambda.
        coef_we   = 1'b1;
        coef_sel  = 1'b1;
        coef_addr = 4'd0;
        coef_data = 32'h0080_0000;
        step(51'd0, 64'd524269, "same-cycle wr");

        // Reset mid-SCAN aborts without done.
        new_timestep = 1'b1;
        tick();
        new_timestep = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("abort out", precursor_neutrons, 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        dp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dp++;
        end
        chk("abort no done", 64'(dp), 64'd0);

        // Fill C0 near 2^63, then a large lambda overflows the sum.
        do_reset();
        wr(1'b0, 4'd0, 32'hFFFF_FFFF);
        wr(1'b1, 4'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(51'h7_FFFF_FFFF_FFFF, 64'd0, $sformatf("fill%0d", i));
        end
        wr(1'b0, 4'd0, 32'h0);
        wr(1'b1, 4'd0, 32'hFFFF_FFFF);
`ifdef PRECURSOR_TRACKER_SATURATE_EN
        step(51'd0, 64'hFFFF_FFFF_FFFF_FFFF, "overflow");
`else
        step(51'd0, 64'hFFFF_FEFF_FFF0_0080, "overflow");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
